// File: rtl/lab3_response_checker.sv
`default_nettype none
// ============================================================================
// lab3_response_checker - exhaustive stimulus/response checker for Lab3.
// Optional response MISR on sig when LAB3_CHK_MISR_EN is defined.
// Revision: 1.0
// ============================================================================
module lab3_response_checker #(
    parameter logic [7:0]  EXP_X  = 8'h96,
    parameter logic [7:0]  EXP_Y  = 8'hE8,
    parameter int unsigned SETTLE = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    output logic       a,
    output logic       b,
    output logic       c,
    input  logic       x,
    input  logic       y,
    output logic       busy,
    output logic       done,
    output logic       pass,
    output logic [3:0] err_count,
    output logic [2:0] first_fail,
    output logic [7:0] sig
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETTLE = 2'd1,
        ST_SAMPLE = 2'd2,
        ST_DONE   = 2'd3
    } state_t;

    localparam logic [3:0] SETTLE_LAST = 4'(SETTLE - 1);

    state_t     state_q, state_d;
    logic [2:0] vec_q, vec_d;
    logic [3:0] cnt_q, cnt_d;
    logic [3:0] err_q, err_d;
    logic [2:0] ff_q, ff_d;
    logic       done_q, done_d;
    logic       pass_q, pass_d;
    logic       busy_q, busy_d;
    logic       mismatch;
    logic       launch;

    assign mismatch = (x != EXP_X[vec_q]) || (y != EXP_Y[vec_q]);
    assign launch   = ((state_q == ST_IDLE) || (state_q == ST_DONE)) && start;

    always_comb begin
        state_d = state_q;
        vec_d   = vec_q;
        cnt_d   = cnt_q;
        err_d   = err_q;
        ff_d    = ff_q;
        done_d  = done_q;
        pass_d  = pass_q;
        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    vec_d   = 3'd0;
                    cnt_d   = 4'd0;
                    err_d   = 4'd0;
                    ff_d    = 3'd0;
                    done_d  = 1'b0;
                    pass_d  = 1'b0;
                    state_d = ST_SETTLE;
                end
            end
            ST_SETTLE: begin
                if (cnt_q == SETTLE_LAST) begin
                    cnt_d   = 4'd0;
                    state_d = ST_SAMPLE;
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end
            ST_SAMPLE: begin
                if (mismatch) begin
                    err_d = err_q + 4'd1;
                    if (err_q == 4'd0) ff_d = vec_q;
                end
                if (vec_q == 3'd7) begin
                    // Final vector's comparison folds into pass directly.
                    state_d = ST_DONE;
                    done_d  = 1'b1;
                    pass_d  = !mismatch && (err_q == 4'd0);
                end else begin
                    vec_d   = vec_q + 3'd1;
                    state_d = ST_SETTLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
        busy_d = (state_d == ST_SETTLE) || (state_d == ST_SAMPLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            vec_q   <= 3'd0;
            cnt_q   <= 4'd0;
            err_q   <= 4'd0;
            ff_q    <= 3'd0;
            done_q  <= 1'b0;
            pass_q  <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            vec_q   <= vec_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
            ff_q    <= ff_d;
            done_q  <= done_d;
            pass_q  <= pass_d;
            busy_q  <= busy_d;
        end
    end

`ifdef LAB3_CHK_MISR_EN
    logic [7:0] sig_q, sig_d;

    always_comb begin
        sig_d = sig_q;
        if (launch) begin
            sig_d = 8'h00;
        end else if (state_q == ST_SAMPLE) begin
            sig_d = {sig_q[6:0], 1'b0} ^ (sig_q[7] ? 8'h71 : 8'h00) ^ {6'b0, x, y};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) sig_q <= 8'h00;
        else     sig_q <= sig_d;
    end

    assign sig = sig_q;
`else
    logic unused_launch;
    assign unused_launch = launch;
    assign sig = 8'h00;
`endif

    assign {a, b, c}  = vec_q;
    assign busy       = busy_q;
    assign done       = done_q;
    assign pass       = pass_q;
    assign err_count  = err_q;
    assign first_fail = ff_q;

endmodule
`default_nettype wire

// File: tb/tb_lab3_response_checker.sv
`default_nettype none
// Scoreboard bench for lab3_response_checker: behavioural Lab3 model on the
// response side, expected vector stream queued at start and popped per cycle.
module tb_lab3_response_checker;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst, start, sel, fault_y0;
    logic start1, start2;
    assign start1 = start & ~sel;
    assign start2 = start & sel;

    logic a1, b1, c1, x1, y1, busy1, done1, pass1;
    logic [3:0] err1;
    logic [2:0] ff1;
    logic [7:0] sig1;
    logic a2, b2, c2, x2, y2, busy2, done2, pass2;
    logic [3:0] err2;
    logic [2:0] ff2;
    logic [7:0] sig2;

    assign x1 = a1 ^ b1 ^ c1;
    assign y1 = fault_y0 ? 1'b0 : ((a1 & b1) | (a1 & c1) | (b1 & c1));
    assign x2 = a2 ^ b2 ^ c2;
    assign y2 = (a2 & b2) | (a2 & c2) | (b2 & c2);

    lab3_response_checker u_dut1 (
        .clk(clk), .rst(rst), .start(start1),
        .a(a1), .b(b1), .c(c1), .x(x1), .y(y1),
        .busy(busy1), .done(done1), .pass(pass1),
        .err_count(err1), .first_fail(ff1), .sig(sig1)
    );

    lab3_response_checker #(.SETTLE(3)) u_dut2 (
        .clk(clk), .rst(rst), .start(start2),
        .a(a2), .b(b2), .c(c2), .x(x2), .y(y2),
        .busy(busy2), .done(done2), .pass(pass2),
        .err_count(err2), .first_fail(ff2), .sig(sig2)
    );

    logic [2:0] o_abc, o_ff;
    logic       o_busy, o_done, o_pass;
    logic [3:0] o_err;
    logic [7:0] o_sig;
    always_comb begin
        o_abc  = sel ? {a2, b2, c2} : {a1, b1, c1};
        o_busy = sel ? busy2 : busy1;
        o_done = sel ? done2 : done1;
        o_pass = sel ? pass2 : pass1;
        o_err  = sel ? err2  : err1;
        o_ff   = sel ? ff2   : ff1;
        o_sig  = sel ? sig2  : sig1;
    end

    int n_vec = 0;
    int n_err = 0;
    logic [2:0] exp_q[$];
    logic [7:0] sig_gold, sig_bad;

    task automatic check_idle(input string tag);
        n_vec++;
        if (o_abc !== 3'd0 || o_busy !== 1'b0 || o_done !== 1'b0 || o_pass !== 1'b0 ||
            o_err !== 4'd0 || o_ff !== 3'd0 || o_sig !== 8'h00) begin
            n_err++;
            $display("FAIL %s: abc=%0d busy=%b done=%b pass=%b err=%0d ff=%0d sig=%h, want all zero",
                     tag, o_abc, o_busy, o_done, o_pass, o_err, o_ff, o_sig);
        end
    endtask

    // Drives one start pulse and checks the whole run; pulse_at >= 0 injects
    // a start while busy, which must not perturb the sequence.
    task automatic run_check(input logic s, input int settle, input logic fault,
                             input int pulse_at, output logic [7:0] sig_out);
        int n;
        logic [3:0] e_err;
        logic [2:0] e_ff, e;
        logic [7:0] e_sig, tx, ty, m;
        logic mx, my;
        sel = s;
        fault_y0 = fault;
        n = 8 * (settle + 1);
        tx = 8'h96;
        ty = 8'hE8;
        e_err = 4'd0;
        e_ff = 3'd0;
        m = 8'h00;
        for (int v = 0; v < 8; v++) begin
            logic [2:0] vv;
            vv = 3'(v);
            mx = vv[2] ^ vv[1] ^ vv[0];
            my = fault ? 1'b0 : ((vv[2] & vv[1]) | (vv[2] & vv[0]) | (vv[1] & vv[0]));
            if (mx != tx[v] || my != ty[v]) begin
                if (e_err == 4'd0) e_ff = vv;
                e_err = e_err + 4'd1;
            end
            m = {m[6:0], 1'b0} ^ (m[7] ? 8'h71 : 8'h00) ^ {6'b0, mx, my};
        end
`ifdef LAB3_CHK_MISR_EN
        e_sig = m;
`else
        e_sig = 8'h00;
`endif
        @(posedge clk); #1;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        for (int j = 0; j < n; j++) exp_q.push_back(3'(j / (settle + 1)));
        for (int j = 0; j < n; j++) begin
            e = exp_q.pop_front();
            n_vec++;
            if (o_abc !== e || o_busy !== 1'b1 || o_done !== 1'b0) begin
                n_err++;
                $display("FAIL seq cyc %0d: abc=%0d busy=%b done=%b, want abc=%0d busy=1 done=0",
                         j, o_abc, o_busy, o_done, e);
            end
            start = (j == pulse_at);
            @(posedge clk); #1;
        end
        start = 1'b0;
        n_vec++;
        if (o_done !== 1'b1 || o_busy !== 1'b0) begin
            n_err++;
            $display("FAIL done_time: done=%b busy=%b, want done=1 busy=0", o_done, o_busy);
        end
        n_vec++;
        if (o_pass !== (e_err == 4'd0) || o_err !== e_err) begin
            n_err++;
            $display("FAIL result: pass=%b err=%0d, want pass=%b err=%0d",
                     o_pass, o_err, (e_err == 4'd0), e_err);
        end
        if (e_err != 4'd0) begin
            n_vec++;
            if (o_ff !== e_ff) begin
                n_err++;
                $display("FAIL first_fail: got %0d want %0d", o_ff, e_ff);
            end
        end
        n_vec++;
        if (o_sig !== e_sig) begin
            n_err++;
            $display("FAIL sig: got %h want %h", o_sig, e_sig);
        end
        sig_out = o_sig;
        @(posedge clk); #1;
        n_vec++;
        if (o_done !== 1'b1 || o_err !== e_err) begin
            n_err++;
            $display("FAIL done_hold: done=%b err=%0d, want done=1 err=%0d", o_done, o_err, e_err);
        end
    endtask

    task automatic test_reset();
        sel = 1'b0;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        check_idle("reset");
        repeat (5) @(posedge clk);
        #1 check_idle("idle5");
    endtask

    task automatic test_golden();
        logic [7:0] s;
        run_check(1'b0, 1, 1'b0, -1, s);
        sig_gold = s;
    endtask

    task automatic test_stuck_y();
        logic [7:0] s;
        run_check(1'b0, 1, 1'b1, -1, s);
        sig_bad = s;
        fault_y0 = 1'b0;
    endtask

    task automatic test_settle3();
        logic [7:0] s;
        run_check(1'b1, 3, 1'b0, -1, s);
        sel = 1'b0;
    endtask

    task automatic test_reset_midrun();
        logic [7:0] s;
        int k;
        sel = 1'b0;
        fault_y0 = 1'b0;
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        k = 0;
        while (o_abc !== 3'd4 && k < 40) begin
            @(posedge clk); #1;
            k++;
        end
        n_vec++;
        if (k >= 40) begin
            n_err++;
            $display("FAIL midrun_wait: abc=%0d never reached 4", o_abc);
        end
        rst = 1'b1;
        @(posedge clk); #1 rst = 1'b0;
        check_idle("midrun_rst");
        run_check(1'b0, 1, 1'b0, 5, s);
    endtask

    task automatic test_misr();
`ifdef LAB3_CHK_MISR_EN
        n_vec++;
        if (sig_gold === sig_bad) begin
            n_err++;
            $display("FAIL misr_distinct: golden=%h faulty=%h, want different", sig_gold, sig_bad);
        end
`endif
    endtask

    initial begin
        rst = 1'b1;
        start = 1'b0;
        sel = 1'b0;
        fault_y0 = 1'b0;
        sig_gold = 8'h00;
        sig_bad = 8'h00;
        test_reset();
        test_golden();
        test_stuck_y();
        test_settle3();
        test_reset_midrun();
        test_misr();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
